// File: rtl/equation_pkg.sv
// Shared types and constants for the equation sequencer.
// Engine indices, state encoding and the one-hot enable helper.
package equation_pkg;

    localparam int NUM_EQ = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 32;

    localparam logic [SEL_W-1:0] EQ_SUM  = 2'd0;
    localparam logic [SEL_W-1:0] EQ_ENG1 = 2'd1;
    localparam logic [SEL_W-1:0] EQ_ENG2 = 2'd2;
    localparam logic [SEL_W-1:0] EQ_ENG3 = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DONE,
        TOUT,
        DRAIN
    } eq_state_t;

    function automatic logic [NUM_EQ-1:0] eq_onehot(
        input logic [SEL_W-1:0] sel
    );
        logic [NUM_EQ-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/equation_run_counter.sv
// Saturating run-length counter for the equation sequencer.
// Presents the next count and its compare against the run limit.
module equation_run_counter #(
    parameter int CNT_W   = 32,
    parameter int LIMIT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               en,
    input  logic [LIMIT_W-1:0] limit,
    output logic [CNT_W-1:0]   count_inc,
    output logic               hit
);

    logic [CNT_W-1:0] count;

    assign count_inc = (&count) ? count : count + CNT_W'(1);
    assign hit       = (count_inc == CNT_W'(limit));

    // Count enabled cycles; clear takes priority, saturate at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/equation_sequencer.sv
// Start/monitor sequencer for the DSP equation engines.
// Drives one engine's enable, watches its done, reports status.
module equation_sequencer #(
    parameter int aw        = 32,
    parameter int NUM_EQ    = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           eq_select,
    input  logic [aw-1:0]        base_address_in,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic [NUM_EQ-1:0]    equation_done,
    output logic [NUM_EQ-1:0]    equation_enable,
    output logic [aw-1:0]        base_address,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 irq,
    output logic [31:0]          cycle_count
);

    import equation_pkg::*;

    eq_state_t            state;
    eq_state_t            state_n;
    logic [1:0]           sel_q;
    logic [aw-1:0]        base_q;
    logic [TIMEOUT_W-1:0] limit_q;
    logic                 done_q;
    logic                 tout_q;
    logic [31:0]          cc_q;

    logic                 accept;
    logic                 set_done;
    logic                 set_tout;
    logic                 run_cyc;
    logic                 done_sel;
    logic                 tout_hit;
    logic                 cnt_hit;
    logic [31:0]          cnt_inc;

    assign run_cyc  = (state == RUN);
    assign done_sel = equation_done[sel_q];
    assign tout_hit = (|limit_q) && cnt_hit;

    equation_run_counter #(
        .CNT_W   (32),
        .LIMIT_W (TIMEOUT_W)
    ) u_cnt (
        .clk       (wb_clk),
        .rst_n     (wb_rst),
        .clear     (accept),
        .en        (run_cyc),
        .limit     (limit_q),
        .count_inc (cnt_inc),
        .hit       (cnt_hit)
    );

    // State register
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state; abort beats done, done beats timeout
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        set_done = 1'b0;
        set_tout = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = DRAIN;
                end else if (done_sel) begin
                    set_done = 1'b1;
                    state_n  = DONE;
                end else if (tout_hit) begin
                    set_tout = 1'b1;
                    state_n  = TOUT;
                end
            end
            DONE:    state_n = DRAIN;
            TOUT:    state_n = DRAIN;
            DRAIN:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Run parameters latched on accept; sticky status on completion
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            sel_q   <= '0;
            base_q  <= '0;
            limit_q <= '0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            cc_q    <= '0;
        end else begin
            if (accept) begin
                sel_q   <= eq_select;
                base_q  <= base_address_in;
                limit_q <= timeout_cycles;
                done_q  <= 1'b0;
                tout_q  <= 1'b0;
            end
            if (set_done) begin
                done_q <= 1'b1;
                cc_q   <= cnt_inc;
            end
            if (set_tout) begin
                tout_q <= 1'b1;
                cc_q   <= cnt_inc;
            end
        end
    end

    assign equation_enable = run_cyc ? eq_onehot(sel_q) : '0;
    assign base_address    = base_q;
    assign busy            = (state != IDLE);
    assign irq             = (state == DONE) || (state == TOUT);
    assign done            = done_q;
    assign timeout_err     = tout_q;
    assign cycle_count     = cc_q;

endmodule

// File: doc/equation_sequencer.md
# equation_sequencer

Control stage directly upstream of the DSP equation engines (sum and siblings). Accepts a start command from the register block and drives the selected engine's `equation_enable` and `base_address`. Monitors that engine's `equation_done`, enforces an optional cycle timeout, and reports busy/done/timeout status, a run-length count and a one-cycle interrupt pulse back to the register block.

## Interface
Parameters:
- `aw`, 32, address width of `base_address`
- `NUM_EQ`, 4, number of equation engines; fixed at 4, so the select is 2 bits
- `TIMEOUT_W`, 16, width of the timeout limit

Ports:
- `wb_clk`  in  1  system clock; all logic on the rising edge
- `wb_rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle command pulse from the register block
- `abort`  in  1  level; cancels a run in progress
- `eq_select`  in  2  engine index for the next run
- `base_address_in`  in  aw  data base address for the next run
- `timeout_cycles`  in  TIMEOUT_W  run limit in cycles; 0 disables the timeout
- `equation_done`  in  NUM_EQ  done flags, one per engine
- `equation_enable`  out  NUM_EQ  one-hot enable to the engines
- `base_address`  out  aw  base address latched at start
- `busy`  out  1  high while a run is active or draining
- `done`  out  1  sticky; the last run completed
- `timeout_err`  out  1  sticky; the last run timed out
- `irq`  out  1  one-cycle pulse on completion or timeout
- `cycle_count`  out  32  enable-high cycles of the last completed or timed-out run

## Operation
- Reset: all outputs are 0; state is IDLE.
- States:
  - IDLE: `start` is accepted only here.
    - On acceptance: latch `eq_select`, `base_address_in` and `timeout_cycles`.
    - Clear `done`, `timeout_err` and the counter.
    - Go to RUN.
  - RUN:
    - `equation_enable[sel]` = 1 and `busy` = 1.
    - The counter increments every cycle.
    - `equation_done[sel]` sampled high → DONE.
    - Counter+1 == `timeout_cycles`, with a nonzero limit and no done → TOUT.
    - `abort` → DRAIN.
  - DONE (1 cycle):
    - Enable low.
    - `done` = 1, `irq` = 1, `cycle_count` = counter+1 latched.
    - → DRAIN.
  - TOUT (1 cycle):
    - Enable low.
    - `timeout_err` = 1, `irq` = 1, `cycle_count` latched as in DONE.
    - → DRAIN.
  - DRAIN (1 cycle): enable low and `busy` = 1; guarantees the engine sees enable low for at least one cycle and drops its done flag. → IDLE.
- Only the selected engine's done bit is observed; the other bits are ignored.
- `start` outside IDLE is dropped silently; status is unchanged.
- Simultaneous events:
  - Done and timeout in the same cycle: done wins.
  - Abort with done or timeout in the same cycle: abort wins. No status change, no `irq`, `cycle_count` unchanged.
- Counter: 32-bit and saturating. Compare against `timeout_cycles` zero-extended.
- `base_address` holds its value until the next accepted start.
- Reset asserted mid-run: enable drops asynchronously; every output returns to 0.

## Timing
- `start` sampled at edge N → `equation_enable` high after edge N. `busy` rises in the same cycle as enable.
- `equation_done` sampled at edge M → enable, `done`, `irq` and `cycle_count` update after edge M.
  - If done is sampled at the first RUN edge, `cycle_count` = 1.
- Timeout: enable stays high for exactly `timeout_cycles` cycles, then drops.
- `busy` falls two cycles after completion is sampled (DONE plus DRAIN).
- Minimum start-to-start spacing is 4 cycles (one RUN cycle, DONE, DRAIN, then start sampled in IDLE).
- `irq` is exactly 1 cycle wide.

## Structure
- Shared package `equation_pkg`:
  - state enumeration: IDLE, RUN, DONE, TOUT, DRAIN
  - `NUM_EQ` and the select-width constant
  - engine index constants, including `EQ_SUM` = 0
- Sub-module `equation_run_counter`:
  - 32-bit saturating counter with clear and enable
  - outputs the `count+1 == limit` compare

## Test plan
- Start, sel=0, base 0x1000, timeout 0; engine 0 raises done 5 cycles after enable → enable 5 cycles, `done` = 1, `irq` 1 cycle, `cycle_count` = 5, `base_address` = 0x1000.
- Start, sel=2, timeout 8; done never arrives → enable exactly 8 cycles, `timeout_err` = 1, `done` = 0, `cycle_count` = 8, `irq` pulse.
- Done and timeout coincide (done on cycle 8, limit 8) → `done` = 1, `timeout_err` = 0.
- Abort on cycle 3 of a run → enable drops next cycle, no `irq`, status unchanged; a second start during RUN/DRAIN is ignored.
- Done asserted on engine 1 while engine 3 is selected → ignored; the run continues until engine 3 reports done.
- `wb_rst` low mid-run → all outputs 0 immediately; after release, a fresh start runs normally.
